// File: rtl/exec_l1_unit.sv
// ---------------------------------------------------------------------------
// exec_l1_unit
//
// Execute stage of the 8-bit L1 datapath. It accepts one operation at a time
// from issue, reads two operands from the 4-entry register file, computes the
// result and writes it back through the register file's single write port.
// The zero/carry flags are updated when the write happens.
//
// Handshake (start/busy/done):
//   start is sampled only while idle (busy=0). Once accepted, busy stays high
//   through the read, execute and write cycles. done pulses for exactly one
//   cycle, together with write_enable, in the cycle the result is presented on
//   write_reg/write_data. start while busy is ignored, never queued.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   start, opcode, rd,
//   rs_a, rs_b                 issue request and its operation fields
//   read_reg_a/b               register file read addresses
//   read_data_a/b              register file read data (combinational)
//   write_enable, write_reg,
//   write_data                 register file write port
//   busy, done                 handshake status
//   flag_zero, flag_carry      flags of the last written result
//   dbg_state                  current FSM state for observation
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 MOV
// ---------------------------------------------------------------------------
module exec_l1_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int MUL_STEPS  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            opcode,
   input  logic [1:0]            rd,
   input  logic [1:0]            rs_a,
   input  logic [1:0]            rs_b,
   output logic [1:0]            read_reg_a,
   output logic [1:0]            read_reg_b,
   input  logic [DATA_WIDTH-1:0] read_data_a,
   input  logic [DATA_WIDTH-1:0] read_data_b,
   output logic                  write_enable,
   output logic [1:0]            write_reg,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  busy,
   output logic                  done,
   output logic                  flag_zero,
   output logic                  flag_carry,
   output logic [1:0]            dbg_state
);

   localparam int W = DATA_WIDTH;
   // Counter must hold both MUL_STEPS and the largest shift amount (7).
   localparam int CNT_W = ($clog2(MUL_STEPS + 1) > 4) ? $clog2(MUL_STEPS + 1) : 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_STEPS);

   // Control state
   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       rd_q, rd_d;
   logic [1:0]       rra_q, rra_d;
   logic [1:0]       rrb_q, rrb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Datapath state
   logic [W-1:0]     res_q, res_d;      // running result (also the SHL shifter)
   logic             cy_q, cy_d;        // carry belonging to res_q
   logic [2*W-1:0]   prod_q, prod_d;    // MUL accumulator
   logic [2*W-1:0]   mcand_q, mcand_d;  // MUL multiplicand, shifted left each step
   logic [W-1:0]     mplier_q, mplier_d;// MUL multiplier, consumed LSB first

   // Write port and flags
   logic [1:0]       wreg_q, wreg_d;
   logic [W-1:0]     wdata_q, wdata_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;

   // Combinational helpers
   logic [W:0]       sum_ext;
   logic [2*W-1:0]   prod_next;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rra_d    = rra_q;
      rrb_d    = rrb_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      cy_d     = cy_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      sum_ext  = '0;
      prod_next = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = opcode;
               rd_d    = rd;
               rra_d   = rs_a;
               rrb_d   = rs_b;
               state_d = ST_READ;
            end
         end

         ST_READ: begin
            // Operands are valid this cycle because read_reg_a/b were
            // registered from rs_a/rs_b at the accepting edge.
            state_d = ST_WRITE;
            cy_d    = 1'b0;
            case (op_q)
               OP_ADD: begin
                  sum_ext = {1'b0, read_data_a} + {1'b0, read_data_b};
                  res_d   = sum_ext[W-1:0];
                  cy_d    = sum_ext[W];
               end
               OP_SUB: begin
                  res_d = read_data_a - read_data_b;
                  cy_d  = (read_data_a < read_data_b);
               end
               OP_AND: res_d = read_data_a & read_data_b;
               OP_OR:  res_d = read_data_a | read_data_b;
               OP_XOR: res_d = read_data_a ^ read_data_b;
               OP_SHL: begin
                  res_d = read_data_a;
                  cnt_d = {{(CNT_W-3){1'b0}}, read_data_b[2:0]};
                  // Zero shift amount goes straight to write with carry=0.
                  if (read_data_b[2:0] != 3'd0) begin
                     state_d = ST_EXEC;
                  end
               end
               OP_MUL: begin
                  prod_d   = '0;
                  mcand_d  = {{W{1'b0}}, read_data_a};
                  mplier_d = read_data_b;
                  cnt_d    = CNT_MUL;
                  state_d  = ST_EXEC;
               end
               OP_MOV: res_d = read_data_a;
               default: res_d = read_data_a;
            endcase
         end

         ST_EXEC: begin
            cnt_d = cnt_q - CNT_ONE;
            if (op_q == OP_SHL) begin
               // Carry ends up as the bit shifted out by the final shift.
               res_d = res_q << 1;
               cy_d  = res_q[W-1];
            end else begin
               prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
               prod_d    = prod_next;
               mcand_d   = mcand_q << 1;
               mplier_d  = mplier_q >> 1;
               res_d     = prod_next[W-1:0];
               cy_d      = |prod_next[2*W-1:W];
            end
            if (cnt_q == CNT_ONE) begin
               state_d = ST_WRITE;
            end
         end

         ST_WRITE: begin
            zero_d  = (wdata_q == '0);
            carry_d = cy_q;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      // The write port registers load only on entry to WRITE, so they hold
      // their values at all other times.
      if (state_d == ST_WRITE && state_q != ST_WRITE) begin
         wreg_d  = rd_q;
         wdata_d = res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rra_q    <= '0;
         rrb_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         cy_q     <= 1'b0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rra_q    <= rra_d;
         rrb_q    <= rrb_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         cy_q     <= cy_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
      end
   end

   assign read_reg_a   = rra_q;
   assign read_reg_b   = rrb_q;
   assign write_enable = (state_q == ST_WRITE);
   assign done         = (state_q == ST_WRITE);
   assign write_reg    = wreg_q;
   assign write_data   = wdata_q;
   assign busy         = (state_q != ST_IDLE);
   assign flag_zero    = zero_q;
   assign flag_carry   = carry_q;
   assign dbg_state    = state_q;

endmodule
